encoder_drain_seq: RTL and testbench

- Parametrised, sequential successor to the team's one-hot 8-to-3 encoders.
- Accepts an N-bit request vector that may have any number of bits set, and stores it.
- Emits the index of each set bit, one per handshake, in priority order, with an end-of-burst flag.
- Sits between button/switch request sources and downstream consumers that need binary indices.

---
 rtl/encoder_pkg.sv | 26 ++
 rtl/prio_index.sv | 29 ++
 rtl/encoder_drain_seq.sv | 133 +++++++++++++
 tb/tb_encoder_drain_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the draining priority encoder.
package encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int N_DEFAULT    = 8;
  localparam int PRIO_MAX_N   = 64;
  localparam int PRIO_MAX_W   = 6;

  // Index of the first set bit in the lower n bits, scanning from the chosen end; 0 if none.
  function automatic int prio_idx(input logic [PRIO_MAX_N-1:0] vec, input int n,
                                  input logic msb_first);
    int r;
    int j;
    r = 0;
    for (int i = 0; i < PRIO_MAX_N; i++) begin
      j = msb_first ? i : (PRIO_MAX_N - 1 - i);
      if ((j < n) && vec[j[PRIO_MAX_W-1:0]]) r = j;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_index.sv
// Combinational priority picker: index and one-hot mask of the highest-priority set bit.
// Supports N up to encoder_pkg::PRIO_MAX_N lines.
module prio_index
  import encoder_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     mask_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [PRIO_MAX_N-1:0] vec_ext;
  int                    idx_int;

  assign vec_ext = PRIO_MAX_N'(vec_i);

  // The AND makes the mask all-zero for an empty vector even though idx_o reads 0.
  always_comb begin
    idx_int = prio_idx(vec_ext, N, MSB_FIRST);
    idx_o   = IDX_W'(idx_int);
    mask_o  = vec_i & (ONE << idx_o);
  end

endmodule

// File: rtl/encoder_drain_seq.sv
// Captures a multi-hot request vector and drains it one binary index per handshake.
// Optional macro ENCODER_DRAIN_COUNT_EN adds the pend_cnt output (popcount of pending bits).
module encoder_drain_seq
  import encoder_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
`ifdef ENCODER_DRAIN_COUNT_EN
  ,
  output logic [IDX_W:0]   pend_cnt
`endif
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0]     pend_rest;
  logic [N-1:0]     prio_src;
  logic [N-1:0]     prio_mask;
  logic [IDX_W-1:0] prio_idx_w;

  // One picker serves both capture (fresh vector) and drain (vector minus the current bit).
  assign pend_rest = pending_q & ~(ONE << out_idx_q);
  assign prio_src  = (state_q == IDLE) ? in_vec : pend_rest;

  prio_index #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec_i  (prio_src),
    .idx_o  (prio_idx_w),
    .mask_o (prio_mask)
  );

`ifdef ENCODER_DRAIN_COUNT_EN
  localparam int CNT_W = IDX_W + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign pend_cnt = cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
`ifdef ENCODER_DRAIN_COUNT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && (in_vec != '0)) begin
          state_d     = DRAIN;
          pending_d   = in_vec;
          out_valid_d = 1'b1;
          out_idx_d   = prio_idx_w;
          out_last_d  = (in_vec == prio_mask);
`ifdef ENCODER_DRAIN_COUNT_EN
          cnt_d       = CNT_W'($countones(in_vec));
`endif
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            pending_d   = '0;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            out_last_d  = 1'b0;
`ifdef ENCODER_DRAIN_COUNT_EN
            cnt_d       = '0;
`endif
          end else begin
            pending_d   = pend_rest;
            out_idx_d   = prio_idx_w;
            out_last_d  = (pend_rest == prio_mask);
`ifdef ENCODER_DRAIN_COUNT_EN
            cnt_d       = cnt_q - CNT_W'(1);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ENCODER_DRAIN_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
`ifdef ENCODER_DRAIN_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == DRAIN);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_encoder_drain_seq.sv
// Scoreboard bench: three encoder instances (N=8 LSB-first, N=8 MSB-first, N=5 LSB-first).
module tb_encoder_drain_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0;
  logic       in_valid5 = 1'b0;
  logic [7:0] in_vec8   = '0;
  logic [4:0] in_vec5   = '0;
  logic       out_ready = 1'b0;
  int         rdy_pct   = 100;

  logic [2:0] ir, ov, ol, bz;
  logic [2:0] oidx [3];
`ifdef ENCODER_DRAIN_COUNT_EN
  logic [3:0] ocnt [3];
`endif

  encoder_drain_seq #(.N(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(ir[0]), .in_vec(in_vec8),
    .out_valid(ov[0]), .out_ready(out_ready), .out_idx(oidx[0]), .out_last(ol[0]),
    .busy(bz[0])
`ifdef ENCODER_DRAIN_COUNT_EN
    , .pend_cnt(ocnt[0])
`endif
  );

  encoder_drain_seq #(.N(8), .MSB_FIRST(1'b1)) u_msb8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(ir[1]), .in_vec(in_vec8),
    .out_valid(ov[1]), .out_ready(out_ready), .out_idx(oidx[1]), .out_last(ol[1]),
    .busy(bz[1])
`ifdef ENCODER_DRAIN_COUNT_EN
    , .pend_cnt(ocnt[1])
`endif
  );

  encoder_drain_seq #(.N(5), .MSB_FIRST(1'b0)) u_lsb5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(ir[2]), .in_vec(in_vec5),
    .out_valid(ov[2]), .out_ready(out_ready), .out_idx(oidx[2]), .out_last(ol[2]),
    .busy(bz[2])
`ifdef ENCODER_DRAIN_COUNT_EN
    , .pend_cnt(ocnt[2])
`endif
  );

  typedef struct {
    int idx;
    int last;
    int cnt;
  } exp_t;

  exp_t exp_q [3][$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: list the set bits in priority order; the remaining count goes with each index.
  function automatic void push_model(input int l, input logic [7:0] v, input int n,
                                     input bit msb);
    int   left;
    int   i;
    exp_t e;
    left = $countones(v);
    for (int k = 0; k < n; k++) begin
      i = msb ? (n - 1 - k) : k;
      if (v[i[2:0]]) begin
        e.idx  = i;
        e.last = (left == 1) ? 1 : 0;
        e.cnt  = left;
        exp_q[l].push_back(e);
        left--;
      end
    end
  endfunction

  // Random backpressure, re-drawn every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: an item is outstanding exactly while the lane is draining.
  always @(negedge clk) begin
    int has;
    if (!rst) begin
      for (int l = 0; l < 3; l++) begin
        has = (exp_q[l].size() != 0) ? 1 : 0;
        chk($sformatf("lane%0d in_ready", l), int'(ir[l]), 1 - has);
        chk($sformatf("lane%0d out_valid", l), int'(ov[l]), has);
        chk($sformatf("lane%0d busy", l), int'(bz[l]), has);
`ifdef ENCODER_DRAIN_COUNT_EN
        if (has == 0) chk($sformatf("lane%0d idle pend_cnt", l), int'(ocnt[l]), 0);
`endif
        if ((has != 0) && ov[l]) begin
          chk($sformatf("lane%0d out_idx", l), int'(oidx[l]), exp_q[l][0].idx);
          chk($sformatf("lane%0d out_last", l), int'(ol[l]), exp_q[l][0].last);
`ifdef ENCODER_DRAIN_COUNT_EN
          chk($sformatf("lane%0d pend_cnt", l), int'(ocnt[l]), exp_q[l][0].cnt);
`endif
          if (out_ready) void'(exp_q[l].pop_front());
        end
      end
    end
  end

  task automatic send(input bit five, input logic [7:0] v);
    int t;
    t = 0;
    if (five) begin
      in_valid5 = 1'b1;
      in_vec5   = v[4:0];
    end else begin
      in_valid8 = 1'b1;
      in_vec8   = v;
    end
    @(negedge clk);
    while (!(five ? ir[2] : (ir[0] && ir[1])) && (t < 200)) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    in_valid5 = 1'b0;
    in_valid8 = 1'b0;
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL send timeout: in_ready low for %0d cycles, expected high", t);
    end else if (five) begin
      push_model(2, v, 5, 1'b0);
    end else begin
      push_model(0, v, 8, 1'b0);
      push_model(1, v, 8, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) && (t < 2000)) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL drain timeout: %0d items left, expected 0",
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-drain of an all-ones vector.
    send(1'b0, 8'hFF);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    for (int l = 0; l < 3; l++) exp_q[l].delete();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("rst lane%0d in_ready", l), int'(ir[l]), 1);
      chk($sformatf("rst lane%0d out_valid", l), int'(ov[l]), 0);
      chk($sformatf("rst lane%0d busy", l), int'(bz[l]), 0);
      chk($sformatf("rst lane%0d out_idx", l), int'(oidx[l]), 0);
      chk($sformatf("rst lane%0d out_last", l), int'(ol[l]), 0);
    end
    @(posedge clk);
    #1;

    // Directed patterns, full throughput.
    send(1'b0, 8'b1010_0100);
    wait_idle();
    // Backpressure with consumer stalled from the first output.
    rdy_pct = 0;
    send(1'b0, 8'h81);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rdy_pct = 100;
    wait_idle();
    send(1'b0, 8'h00);
    send(1'b0, 8'h10);
    send(1'b0, 8'h80);
    send(1'b0, 8'hFF);
    send(1'b1, 8'h1F);
    send(1'b1, 8'h10);
    wait_idle();

    // Randomized traffic with random backpressure.
    rdy_pct = 70;
    repeat (40) begin
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) v = 8'h00;
      send(1'b0, v);
    end
    repeat (25) begin
      v = 8'($urandom_range(0, 31));
      send(1'b1, v);
    end
    rdy_pct = 100;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
